// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Entries carry the fetch PC alongside the returned word so decode sees both together.
package instr_fetch_unit_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Circular FIFO of {pc, instr} entries with synchronous flush; head is visible the cycle after a push.
// No internal backpressure: the producer never pushes into a full queue, and pops only while count is non-zero.
module fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_dat_i,
    input  logic                   pop_i,
    output fetch_entry_t           head_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;

    // Storage is cleared on reset so the head reads as all-zero until the first push.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_dat_i;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop_i) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_dat_o = mem_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads imem over req/ack and queues {pc, instr} for decode; head valid the cycle after ack.
// Backpressure: no request is issued unless a queue slot is free for its result; redirect flushes and squashes in-flight reads.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'd0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    instr_pc_o,
    output logic [PC_W-1:0]    instr_pc4_o,
    input  logic               instr_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;
    fetch_entry_t    push_dat;
    fetch_entry_t    head_dat;

    assign imem_req_o    = (state_q != IDLE);
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = (count != '0) && !redirect_i;

    assign push       = (state_q == REQ) && imem_ack_i && !redirect_i;
    assign pop        = instr_valid_o && instr_ready_i;
    assign count_next = count + CW'(push) - CW'(pop);
    assign push_dat   = '{pc: fetch_pc_q, instr: imem_data_i};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (push) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
        end
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~32'h3;
        end

        case (state_q)
            IDLE: begin
                if (redirect_i || (count_next < CW'(DEPTH))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    state_d = imem_ack_i ? REQ : DROP;
                end else if (imem_ack_i) begin
                    state_d = (count_next < CW'(DEPTH)) ? REQ : IDLE;
                end
            end
            // The squashed read completes on ack; a redirect in that same cycle just updates the target.
            DROP: begin
                if (imem_ack_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Memory keeps seeing the squashed address until its ack arrives.
        addr_d = (state_d == DROP) ? addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (redirect_i),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .count_o    (count)
    );

    assign instr_o     = head_dat.instr;
    assign instr_pc_o  = head_dat.pc;
    assign instr_pc4_o = head_dat.pc + PC_INC;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hand-checked scenarios plus a stream-level model of the decode queue.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk_i;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [31:0] instr_pc4_o;
    logic        instr_ready_i;

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_pc4_o   (instr_pc4_o),
        .instr_ready_i (instr_ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
    endtask

    // Instruction memory: acks after mem_lat wait cycles, tolerates a dropped request.
    int wait_cnt;
    initial begin
        imem_ack_i  = 1'b0;
        imem_data_i = '0;
        wait_cnt    = 0;
        forever begin
            @(posedge clk_i);
            #1;
            imem_ack_i = 1'b0;
            if (rst_i && imem_req_o) begin
                if (wait_cnt >= mem_lat) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = memf(imem_addr_o);
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Stream model: entries seen by decode are consecutive words from the last redirect target.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] next_pc;
    logic        stale;
    logic        pend;
    logic [31:0] pend_addr;
    logic        exp_valid;

    initial begin
        next_pc = 32'd0;
        stale   = 1'b0;
        pend    = 1'b0;
        pend_addr = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                mq.delete();
                next_pc = 32'd0;
                stale   = 1'b0;
                pend    = 1'b0;
            end else begin
                exp_valid = (mq.size() != 0) && !redirect_i;
                chk("m_valid", instr_valid_o, exp_valid);
                if (exp_valid) begin
                    chk("m_instr", instr_o, mq[0].instr);
                    chk("m_pc", instr_pc_o, mq[0].pc);
                    chk("m_pc4", instr_pc4_o, mq[0].pc + 32'd4);
                end
                if (pend) begin
                    chk("m_req_held", imem_req_o, 1);
                    chk("m_addr_stable", imem_addr_o, pend_addr);
                end
                if (imem_req_o && !stale) begin
                    chk("m_addr", imem_addr_o, next_pc);
                end
                pend      = imem_req_o && !imem_ack_i;
                pend_addr = imem_addr_o;
                if (redirect_i) begin
                    stale   = imem_req_o && !imem_ack_i;
                    mq.delete();
                    next_pc = redirect_pc_i & ~32'h3;
                end else begin
                    if (exp_valid && instr_ready_i) begin
                        void'(mq.pop_front());
                    end
                    if (imem_req_o && imem_ack_i) begin
                        if (stale) begin
                            stale = 1'b0;
                        end else begin
                            chk("m_no_overflow", (mq.size() < DEPTH), 1);
                            mq.push_back('{pc: next_pc, instr: memf(next_pc)});
                            next_pc = next_pc + 32'd4;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    logic [31:0] pat;
    logic        got;

    initial begin
        rst_i         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b1;
        mem_lat       = 0;

        // Reset values
        @(negedge clk_i);
        chk("rst_req", imem_req_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", instr_pc_o, 0);
        chk("rst_pc4", instr_pc4_o, 32'd4);
        chk("rst_addr", imem_addr_o, 0);

        // Zero-wait streaming, decode always ready
        step();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t1_req_release", imem_req_o, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("t1_req", imem_req_o, 1);
            chk("t1_addr", imem_addr_o, 32'(i * 4));
            if (i > 0) begin
                chk("t1_valid", instr_valid_o, 1);
                chk("t1_pc", instr_pc_o, 32'((i - 1) * 4));
                chk("t1_pc4", instr_pc4_o, 32'(i * 4));
            end
        end

        // Decode stalled: queue fills to DEPTH and requests stop
        instr_ready_i = 1'b0;
        do_reset();
        repeat (10) @(negedge clk_i);
        chk("t2_req_low", imem_req_o, 0);
        chk("t2_valid", instr_valid_o, 1);
        chk("t2_head_pc", instr_pc_o, 0);
        chk("t2_head_instr", instr_o, 32'hC0DE_0000);
        step();
        instr_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("t2_drain_pc", instr_pc_o, 32'(i * 4));
            if (i == 1) begin
                chk("t2_req_again", imem_req_o, 1);
                chk("t2_addr_16", imem_addr_o, 32'd16);
            end
        end

        // 3-cycle memory with a redirect while the read is outstanding
        mem_lat = 3;
        do_reset();
        step();
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        @(negedge clk_i);
        chk("t3_valid_redir", instr_valid_o, 0);
        chk("t3_addr_hold0", imem_addr_o, 0);
        step();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("t3_req_drop", imem_req_o, 1);
        chk("t3_addr_hold1", imem_addr_o, 0);
        step();
        @(negedge clk_i);
        chk("t3_addr_hold2", imem_addr_o, 0);
        chk("t3_no_stale", instr_valid_o, 0);
        step();
        @(negedge clk_i);
        chk("t3_req_target", imem_req_o, 1);
        chk("t3_addr_target", imem_addr_o, 32'h40);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (instr_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("t3_valid_seen", got, 1);
        chk("t3_first_pc", instr_pc_o, 32'h40);
        chk("t3_first_instr", instr_o, 32'hC0DE_0040);

        // Redirect coincident with ack and an active pop; unaligned target
        mem_lat = 0;
        do_reset();
        step();
        step();
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h102;
        @(negedge clk_i);
        chk("t4_valid_low", instr_valid_o, 0);
        step();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("t4_addr", imem_addr_o, 32'h100);
        chk("t4_empty", instr_valid_o, 0);
        step();
        @(negedge clk_i);
        chk("t4_valid", instr_valid_o, 1);
        chk("t4_pc", instr_pc_o, 32'h100);
        chk("t4_pc4", instr_pc4_o, 32'h104);
        chk("t4_instr", instr_o, 32'hC0DE_0100);

        // PC wrap at the top of the address space
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        @(negedge clk_i);
        chk("t5_valid_low", instr_valid_o, 0);
        step();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("t5_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        step();
        @(negedge clk_i);
        chk("t5_pc", instr_pc_o, 32'hFFFF_FFFC);
        chk("t5_pc4_wrap", instr_pc4_o, 32'h0);
        chk("t5_instr", instr_o, 32'h3F21_FFFC);
        chk("t5_addr_wrap", imem_addr_o, 32'h0);
        step();
        @(negedge clk_i);
        chk("t5_next_pc", instr_pc_o, 32'h0);
        chk("t5_next_pc4", instr_pc4_o, 32'h4);

        // Mixed stall pattern, 1-wait memory, redirect mid-stream (model-checked)
        mem_lat = 1;
        pat     = 32'hB6D3_5A9C;
        for (int i = 0; i < 32; i++) begin
            step();
            instr_ready_i = pat[i];
            redirect_i    = (i == 12);
            redirect_pc_i = 32'h203;
        end
        step();
        redirect_i    = 1'b0;
        instr_ready_i = 1'b1;
        mem_lat       = 0;
        repeat (8) step();

        // Reset in the middle of a request with two entries queued
        instr_ready_i = 1'b0;
        do_reset();
        step();
        step();
        step();
        @(negedge clk_i);
        chk("t6_pre_valid", instr_valid_o, 1);
        chk("t6_pre_req", imem_req_o, 1);
        rst_i = 1'b0;
        #1;
        chk("t6_req", imem_req_o, 0);
        chk("t6_valid", instr_valid_o, 0);
        chk("t6_instr", instr_o, 0);
        chk("t6_pc", instr_pc_o, 0);
        chk("t6_pc4", instr_pc4_o, 32'd4);
        chk("t6_addr", imem_addr_o, 0);
        step();
        step();
        rst_i         = 1'b1;
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        chk("t6_req_release", imem_req_o, 0);
        step();
        @(negedge clk_i);
        chk("t6_restart_req", imem_req_o, 1);
        chk("t6_restart_addr", imem_addr_o, 0);
        step();
        @(negedge clk_i);
        chk("t6_restart_pc", instr_pc_o, 0);
        chk("t6_restart_valid", instr_valid_o, 1);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage placed directly upstream of the CPU datapath's decode/register-file logic. It owns the program counter and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency. Returned words go into a small queue with their PCs, and the unit presents them to decode over a valid/ready interface. A branch/jump/jr redirect from downstream flushes the queue, squashes any in-flight read and restarts fetch at the target.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'd0: first fetch address after reset.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- redirect_i  in  1  downstream taken branch/jump/jr this cycle.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (treated as 0).
- imem_req_o  out  1  read request to instruction memory.
- imem_addr_o  out  32  word-aligned read address; stable while imem_req_o is high.
- imem_ack_i  in  1  read complete; imem_data_i is valid this cycle; meaningful only while imem_req_o is high.
- imem_data_i  in  32  instruction word.
- instr_valid_o  out  1  head entry is available to decode.
- instr_o  out  32  head instruction.
- instr_pc_o  out  32  PC of the head instruction.
- instr_pc4_o  out  32  instr_pc_o + 4, used by decode as the jal/link value.
- instr_ready_i  in  1  decode accepts the head this cycle.

## Operation
- FSM states:
  - IDLE: no request.
  - REQ: request to fetch_pc outstanding.
  - DROP: request outstanding, but its result will be discarded.
- imem_req_o is high in REQ and DROP. imem_addr_o holds the registered fetch address.
- **Leaving IDLE:** go to REQ when count < DEPTH. Entering REQ reserves one queue slot, so the queue can never overflow.
- **REQ with ack:** push {fetch_pc, imem_data_i} and set fetch_pc += 4 (mod 2^32). Next state is REQ if count_next < DEPTH, otherwise IDLE. Back-to-back requests are allowed.
- **Queue bookkeeping:**
  - Pop occurs when instr_valid_o and instr_ready_i are both high.
  - count_next = count + push − pop.
  - Push and pop in the same cycle leave count unchanged.
- **Redirect.** redirect_i has priority over everything else:
  - count ← 0 and head/tail ← 0. Any pop in that cycle is void.
  - fetch_pc ← {redirect_pc_i[31:2], 2'b00}.
  - From REQ without ack in the same cycle: go to DROP. Address and request stay stable toward memory until ack, and the ack data is discarded.
  - From REQ with ack in the same cycle: discard the data and go to REQ at the new PC.
  - From IDLE: go to REQ.
  - From DROP: remain in DROP; only the latest target is kept.
- **DROP with ack:** discard the data and go to REQ at fetch_pc.
- **instr_valid_o** = (count != 0) && !redirect_i. This is the only combinational input-to-output path.
- **Reset values:**
  - Outputs: imem_req_o 0, instr_valid_o 0, instr_o 0, instr_pc_o 0, instr_pc4_o 4. imem_addr_o = RESET_PC.
  - Internal: state IDLE, fetch_pc RESET_PC, count 0.
- Reset asserted mid-request abandons the request immediately. The memory model must tolerate a dropped req.

## Timing
- After rst_i deasserts, IDLE→REQ on the first edge, so imem_req_o goes high one cycle after release.
- Ack at cycle t makes instr_valid_o high at t+1 with the corresponding head, provided the queue was empty.
- With single-cycle memory (ack in the same cycle as req) and decode always ready, sustained throughput is 1 instruction/cycle.
- Redirect at cycle t: instr_valid_o is low at t. The first new-target instruction is visible no earlier than t+2 (zero-wait memory, no DROP).
- A full queue with decode stalled leaves imem_req_o low until the first pop. req rises the cycle after that pop.

## Structure
- Shared package:
  - fetch_state_t enum {IDLE, REQ, DROP}.
  - Instruction word width and PC width constants (32).
  - The PC increment constant (4).
- One natural sub-module: fetch_queue. It is a synchronous FIFO of DEPTH × 64-bit entries {pc, instr} with push, pop, flush and count outputs. Pointers wrap modulo DEPTH.
- The FSM, PC register and redirect logic live in instr_fetch_unit.

## Test plan
- Reset then zero-wait ack, ready high: imem_addr_o sequence 0, 4, 8, 12. instr_pc_o follows one cycle later, instr_pc4_o = pc+4, and valid stays high continuously.
- Decode ready low for 10 cycles, zero-wait memory: exactly DEPTH (4) words enqueue and req drops. Raise ready: words drain in order 0, 4, 8, 12, and req reasserts at address 16 the cycle after the first pop.
- 3-cycle memory latency with redirect_i to 0x40 during the wait: the address stays at the old value until ack, that data never appears, then req goes to 0x40 and the first valid instruction has pc 0x40.
- Redirect coincident with ack and with an active pop: the queue empties, valid is low that cycle, and the next output is the target instruction (target 0x102 is fetched as 0x100).
- PC wrap: redirect to 0xFFFFFFFC. The next fetch is 0x00000000, and instr_pc4_o for the first word is 0.
- Assert rst_i mid-request with 2 entries queued: outputs immediately return to reset values. After release, fetch restarts at RESET_PC.
